// File: rtl/vector_irq_ctrl.sv
// ----------------------------------------------------------------------------
// vector_irq_ctrl
//
// Four-source vectored interrupt controller. Level requests from peripherals
// are qualified by per-source enables; the highest-priority pending source
// (lowest index) is offered to the CPU through virq. On the CPU vector-read
// strobe the winner is latched, its vector is driven on ivec with iack, and
// the serviced peripheral receives a single-cycle irq_ack pulse. A one-cycle
// release state separates iack falling from virq rising again.
//
// Ports
//   wb_clk_i   in   1  clock, rising edge
//   wb_rst_i   in   1  synchronous active-high reset
//   irq_req    in   4  level interrupt requests, bit 0 highest priority
//   irq_ie     in   4  per-source enables
//   irq_ack    out  4  one-cycle acknowledge pulse to the serviced source
//   virq       out  1  vectored interrupt request to the CPU
//   istb       in   1  CPU vector-read strobe
//   ivec       out 16  vector bus (zero whenever iack is low)
//   iack       out  1  vector-valid acknowledge to the CPU
// ----------------------------------------------------------------------------
module vector_irq_ctrl #(
   parameter logic [15:0] VEC0   = 16'o000060,
   parameter logic [15:0] VEC1   = 16'o000064,
   parameter logic [15:0] VEC2   = 16'o000100,
   parameter logic [15:0] VEC3   = 16'o000300,
   parameter logic [15:0] DEFVEC = 16'o000000
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic [3:0]  irq_req,
   input  logic [3:0]  irq_ie,
   output logic [3:0]  irq_ack,
   output logic        virq,
   input  logic        istb,
   output logic [15:0] ivec,
   output logic        iack
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_REL  = 2'd3
   } state_t;

   // Index of the highest-priority (lowest-numbered) pending source.
   // The result is only meaningful when at least one bit is set.
   function automatic logic [1:0] win_idx(input logic [3:0] p);
      logic [1:0] idx;
      if (p[0]) begin
         idx = 2'd0;
      end else if (p[1]) begin
         idx = 2'd1;
      end else if (p[2]) begin
         idx = 2'd2;
      end else begin
         idx = 2'd3;
      end
      return idx;
   endfunction

   // Vector associated with a source index.
   function automatic logic [15:0] vec_of(input logic [1:0] idx);
      logic [15:0] v;
      case (idx)
         2'd0:    v = VEC0;
         2'd1:    v = VEC1;
         2'd2:    v = VEC2;
         2'd3:    v = VEC3;
         default: v = DEFVEC;
      endcase
      return v;
   endfunction

   state_t      state_r;
   state_t      state_nxt_s;
   logic [3:0]  pend_s;
   logic        any_s;
   logic [1:0]  idx_s;
   logic        latch_s;
   logic        virq_r;
   logic        iack_r;
   logic [15:0] ivec_r;
   logic [3:0]  irq_ack_r;
   logic        virq_nxt_s;
   logic        iack_nxt_s;
   logic [15:0] ivec_nxt_s;
   logic [3:0]  irq_ack_nxt_s;

   assign pend_s = irq_req & irq_ie;
   assign any_s  = |pend_s;
   assign idx_s  = win_idx(pend_s);

   // Next-state decode; latch_s marks the edge where the winner is captured.
   always_comb begin
      state_nxt_s = state_r;
      latch_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            // A stray strobe in IDLE is answered too, so the CPU never hangs.
            if (istb) begin
               latch_s     = 1'b1;
               state_nxt_s = ST_ACK;
            end else if (any_s) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (istb) begin
               latch_s     = 1'b1;
               state_nxt_s = ST_ACK;
            end else if (!any_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_ACK: begin
            if (!istb) begin
               state_nxt_s = ST_REL;
            end else begin
               state_nxt_s = ST_ACK;
            end
         end
         ST_REL: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Output decode: values the registered outputs take on the next edge.
   always_comb begin
      virq_nxt_s    = (state_nxt_s == ST_REQ);
      iack_nxt_s    = (state_nxt_s == ST_ACK);
      ivec_nxt_s    = 16'd0;
      irq_ack_nxt_s = 4'd0;
      if (latch_s) begin
         if (any_s) begin
            ivec_nxt_s    = vec_of(idx_s);
            irq_ack_nxt_s = 4'b0001 << idx_s;
         end else begin
            ivec_nxt_s    = DEFVEC;
            irq_ack_nxt_s = 4'd0;
         end
      end else if (state_nxt_s == ST_ACK) begin
         // Vector stays frozen for the whole ACK phase.
         ivec_nxt_s    = ivec_r;
         irq_ack_nxt_s = 4'd0;
      end else begin
         ivec_nxt_s    = 16'd0;
         irq_ack_nxt_s = 4'd0;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_r   <= ST_IDLE;
         virq_r    <= 1'b0;
         iack_r    <= 1'b0;
         ivec_r    <= 16'd0;
         irq_ack_r <= 4'd0;
      end else begin
         state_r   <= state_nxt_s;
         virq_r    <= virq_nxt_s;
         iack_r    <= iack_nxt_s;
         ivec_r    <= ivec_nxt_s;
         irq_ack_r <= irq_ack_nxt_s;
      end
   end

   assign virq    = virq_r;
   assign iack    = iack_r;
   assign ivec    = ivec_r;
   assign irq_ack = irq_ack_r;

endmodule

// File: tb/tb_vector_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vector_irq_ctrl
//
// Directed bench for vector_irq_ctrl. Inputs change 1 time unit after each
// rising edge and outputs are sampled at that same point, so every check
// observes the values registered by the edge just taken.
// ----------------------------------------------------------------------------
module tb_vector_irq_ctrl;

   logic        wb_clk_i;
   logic        wb_rst_i;
   logic [3:0]  irq_req;
   logic [3:0]  irq_ie;
   logic [3:0]  irq_ack;
   logic        virq;
   logic        istb;
   logic [15:0] ivec;
   logic        iack;

   int checks_cnt;
   int errors_cnt;

   localparam logic [15:0] V0 = 16'h0030;
   localparam logic [15:0] V1 = 16'h0034;
   localparam logic [15:0] V2 = 16'h0040;
   localparam logic [15:0] V3 = 16'h00C0;

   vector_irq_ctrl dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_i (wb_rst_i),
      .irq_req  (irq_req),
      .irq_ie   (irq_ie),
      .irq_ack  (irq_ack),
      .virq     (virq),
      .istb     (istb),
      .ivec     (ivec),
      .iack     (iack)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt = checks_cnt + 1;
      if (got !== exp) begin
         errors_cnt = errors_cnt + 1;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Checks all four outputs at once.
   task automatic chk_out(input string tag, input logic v, input logic a,
                          input logic [15:0] vec, input logic [3:0] ack);
      chk({tag, ".virq"},    {31'd0, virq}, {31'd0, v});
      chk({tag, ".iack"},    {31'd0, iack}, {31'd0, a});
      chk({tag, ".ivec"},    {16'd0, ivec}, {16'd0, vec});
      chk({tag, ".irq_ack"}, {28'd0, irq_ack}, {28'd0, ack});
   endtask

   initial begin
      checks_cnt = 0;
      errors_cnt = 0;
      wb_rst_i = 1'b1;
      irq_req  = 4'b0000;
      irq_ie   = 4'hF;
      istb     = 1'b0;
      tick();
      tick();
      chk_out("reset", 1'b0, 1'b0, 16'd0, 4'd0);

      // Single request on source 2
      wb_rst_i = 1'b0;
      irq_req  = 4'b0100;
      tick();
      chk_out("single.req", 1'b1, 1'b0, 16'd0, 4'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("single.hold.virq", {31'd0, virq}, 32'd1);
      istb = 1'b1;
      tick();
      chk_out("single.ack", 1'b0, 1'b1, V2, 4'b0100);
      irq_req = 4'b0000;
      tick();
      chk_out("single.ack2", 1'b0, 1'b1, V2, 4'b0000);
      istb = 1'b0;
      tick();
      chk_out("single.rel", 1'b0, 1'b0, 16'd0, 4'd0);
      tick();

      // Priority: sources 1 and 3 together
      irq_req = 4'b1010;
      tick();
      chk("prio.virq1", {31'd0, virq}, 32'd1);
      istb = 1'b1;
      tick();
      chk_out("prio.ack1", 1'b0, 1'b1, V1, 4'b0010);
      irq_req = 4'b1000;
      tick();
      istb = 1'b0;
      tick();
      chk_out("prio.rel1", 1'b0, 1'b0, 16'd0, 4'd0);
      tick();
      chk("prio.dead.virq", {31'd0, virq}, 32'd0);
      tick();
      chk("prio.virq2", {31'd0, virq}, 32'd1);
      istb = 1'b1;
      tick();
      chk_out("prio.ack2", 1'b0, 1'b1, V3, 4'b1000);
      irq_req = 4'b0000;
      tick();
      istb = 1'b0;
      tick();
      tick();

      // Withdrawn request, then a lone strobe
      irq_req = 4'b0001;
      tick();
      chk("wd.virq.up", {31'd0, virq}, 32'd1);
      tick();
      tick();
      irq_req = 4'b0000;
      tick();
      chk("wd.virq.down", {31'd0, virq}, 32'd0);
      tick();
      istb = 1'b1;
      tick();
      chk_out("wd.defvec", 1'b0, 1'b1, 16'd0, 4'd0);
      istb = 1'b0;
      tick();
      chk("wd.rel.iack", {31'd0, iack}, 32'd0);
      tick();

      // Mask: source 0 disabled
      irq_req = 4'b0001;
      irq_ie  = 4'b1110;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("mask.virq.low", {31'd0, virq}, 32'd0);
      end
      irq_ie = 4'hF;
      tick();
      chk("mask.virq.up", {31'd0, virq}, 32'd1);

      // Reset in the middle of ACK
      istb = 1'b1;
      tick();
      chk_out("rst.ack", 1'b0, 1'b1, V0, 4'b0001);
      wb_rst_i = 1'b1;
      tick();
      chk_out("rst.abort", 1'b0, 1'b0, 16'd0, 4'd0);
      istb = 1'b0;
      tick();
      wb_rst_i = 1'b0;
      tick();
      chk("rst.release.virq", {31'd0, virq}, 32'd1);
      istb = 1'b1;
      tick();
      irq_req = 4'b0000;
      istb = 1'b0;
      tick();
      tick();

      // Vector stability while requests change during ACK
      irq_req = 4'b0100;
      tick();
      chk("stab.virq", {31'd0, virq}, 32'd1);
      istb = 1'b1;
      tick();
      chk_out("stab.ack", 1'b0, 1'b1, V2, 4'b0100);
      irq_req = 4'b0001;
      tick();
      chk_out("stab.hold1", 1'b0, 1'b1, V2, 4'b0000);
      tick();
      chk("stab.hold2.ivec", {16'd0, ivec}, {16'd0, V2});
      istb = 1'b0;
      tick();
      chk_out("stab.rel", 1'b0, 1'b0, 16'd0, 4'd0);
      tick();
      chk("stab.dead.virq", {31'd0, virq}, 32'd0);
      tick();
      chk("stab.rereq.virq", {31'd0, virq}, 32'd1);

      // Strobe still high when reset releases
      irq_req  = 4'b0010;
      istb     = 1'b1;
      wb_rst_i = 1'b1;
      tick();
      wb_rst_i = 1'b0;
      tick();
      chk_out("stray.after.rst", 1'b0, 1'b1, V1, 4'b0010);
      istb = 1'b0;
      irq_req = 4'b0000;
      tick();
      chk("stray.rel.ivec", {16'd0, ivec}, 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
